// File: rtl/arb_pkg.sv
// Shared types and defaults for the two-input stream arbiter.
// Provides the grant FSM state type and default parameter values.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } arb_state_t;

    localparam int WIDTH_DEFAULT = 8;
    localparam int BURST_DEFAULT = 4;

endpackage

// File: rtl/mux.sv
// Two-way word multiplexer feeding the arbiter output register.
// Ports: sel picks in1 when high, in0 when low; dout is the chosen word.
module mux #(
    parameter int WIDTH = 8
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic [WIDTH-1:0] dout
);

    assign dout = sel ? in1 : in0;

endmodule

// File: rtl/stream_arb_2to1.sv
// Round-robin 2:1 stream arbiter with burst-limited grants and a
// single-entry registered output stage.
// Ports: clk/rst (async active-high), in0_*/in1_* valid/ready producers,
// sel (current grant index), out_* valid/ready consumer side.
module stream_arb_2to1
    import arb_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int BURST = BURST_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    output logic             in1_ready,
    output logic             sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    localparam int CW = $clog2(BURST + 1);
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t BURST_C = cnt_t'(BURST);
    localparam cnt_t ONE_C   = cnt_t'(1);

    arb_state_t       state_q, state_d;
    logic             sel_q, sel_d;
    logic             last_q, last_d;
    cnt_t             beat_q, beat_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [WIDTH-1:0] mux_out;

    logic out_free;
    logic xfer;
    logic own_valid;
    logic oth_valid;
    logic release_g;

    mux #(.WIDTH(WIDTH)) u_mux (
        .sel  (sel_q),
        .in0  (in0_data),
        .in1  (in1_data),
        .dout (mux_out)
    );

    assign out_free  = !out_valid_q || out_ready;
    assign in0_ready = (state_q == G0) && out_free;
    assign in1_ready = (state_q == G1) && out_free;
    assign xfer      = (in0_valid && in0_ready) || (in1_valid && in1_ready);

    // Valid of the source holding the grant and of the other one.
    assign own_valid = (state_q == G1) ? in1_valid : in0_valid;
    assign oth_valid = (state_q == G1) ? in0_valid : in1_valid;

    // A grant ends on the burst-closing beat, or as soon as its owner
    // goes quiet (even under stall, since no beat is owed then).
    assign release_g = (xfer && (beat_q + ONE_C == BURST_C)) || !own_valid;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        beat_d  = beat_q;
        unique case (state_q)
            IDLE: begin
                if (in0_valid && in1_valid) begin
                    state_d = last_q ? G0 : G1;
                end else if (in0_valid) begin
                    state_d = G0;
                end else if (in1_valid) begin
                    state_d = G1;
                end
            end
            G0, G1: begin
                if (release_g) begin
                    last_d = (state_q == G1);
                    beat_d = '0;
                    if (oth_valid) begin
                        state_d = (state_q == G1) ? G0 : G1;
                    end else if (!own_valid) begin
                        state_d = IDLE;
                    end
                end else if (xfer) begin
                    beat_d = beat_q + ONE_C;
                end
            end
            default: state_d = IDLE;
        endcase
        sel_d = (state_d == G1);
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = mux_out;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sel_q       <= 1'b0;
            last_q      <= 1'b1;
            beat_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            last_q      <= last_d;
            beat_q      <= beat_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign sel       = sel_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule
